// File: rtl/mpd_pkg.sv
// mpd_pkg
// Shared types and constants for the multi-pattern detector.
//   PAT_LEN      pattern length in bits (>=2). The channel config struct is
//                sized from it, so it lives here and the modules pick it up
//                through the import.
//   FILL_W       width of the per-channel fill counter (0..PAT_LEN)
//   chan_cfg_t   one channel's programmed pattern, care-mask and overlap mode
//   fill_state_t FILLING until PAT_LEN bits have been seen, then ARMED
//   pattern_match  masked compare of a history window against a config
package mpd_pkg;

   localparam int PAT_LEN = 3;
   localparam int FILL_W  = $clog2(PAT_LEN + 1);

   typedef struct packed {
      logic [PAT_LEN-1:0] pat;
      logic [PAT_LEN-1:0] mask;
      logic               overlap;
   } chan_cfg_t;

   typedef enum logic {
      FILLING = 1'b0,
      ARMED   = 1'b1
   } fill_state_t;

   // A channel with an all-zero mask is disabled, so it must never report a
   // match even though every bit would trivially compare equal.
   function automatic logic pattern_match(input logic [PAT_LEN-1:0] hist,
                                          input chan_cfg_t           cfg);
      return (((hist ^ cfg.pat) & cfg.mask) == '0) && (cfg.mask != '0);
   endfunction

endpackage

// File: rtl/mpd_channel.sv
// mpd_channel
// One pattern channel: config registers, history shift register with a
// saturating fill count, masked match logic, registered hit pulse and an
// optional saturating hit counter.
// Build option: define HIT_COUNT_EN to include the hit counter; otherwise
// hit_cnt is tied to 0 and cnt_clr is ignored.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   in_valid      in_bit is consumed this cycle
//   in_bit        serial data bit
//   cfg_we        config write already decoded for this channel
//   cfg_pat       pattern, MSB = oldest bit
//   cfg_mask      1 = compare bit, 0 = don't care
//   cfg_overlap   1 = overlapping, 0 = non-overlapping detection
//   cnt_clr       clear the hit counter
//   hit           registered one-cycle hit pulse
//   match         combinational next value of hit (feeds the top's any_hit)
//   hit_cnt       saturating hit count
module mpd_channel
   import mpd_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic               in_bit,
   input  logic               cfg_we,
   input  logic [PAT_LEN-1:0] cfg_pat,
   input  logic [PAT_LEN-1:0] cfg_mask,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               hit,
   output logic               match,
   output logic [CNT_W-1:0]   hit_cnt
);

   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

   chan_cfg_t          cfg_q, cfg_n;
   logic [PAT_LEN-1:0] hist_q, hist_n, hist_shift;
   logic [FILL_W-1:0]  fill_q, fill_n, fill_inc;
   fill_state_t        state_q, state_n;

   // All channel state lives here. Reset clears the config too, which leaves
   // every channel disabled (mask 0) until it is programmed.
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         state_q <= FILLING;
         hit     <= 1'b0;
      end else begin
         cfg_q   <= cfg_n;
         hist_q  <= hist_n;
         fill_q  <= fill_n;
         state_q <= state_n;
         hit     <= match;
      end
   end

   // Next-state logic. A config write takes priority over a same-cycle bit:
   // the channel restarts empty with the new config and the bit is dropped.
   // Otherwise an accepted bit shifts into the history and advances the fill
   // count, which sticks at PAT_LEN once ARMED. In non-overlapping mode a hit
   // empties the fill count so the bits that formed it cannot be reused; the
   // stale history bits are then ignored until the window refills.
   always_comb begin
      cfg_n      = cfg_q;
      hist_n     = hist_q;
      fill_n     = fill_q;
      state_n    = state_q;
      match      = 1'b0;
      hist_shift = {hist_q[PAT_LEN-2:0], in_bit};
      fill_inc   = (state_q == ARMED) ? FILL_FULL : fill_q + FILL_W'(1);

      if (cfg_we) begin
         cfg_n.pat     = cfg_pat;
         cfg_n.mask    = cfg_mask;
         cfg_n.overlap = cfg_overlap;
         hist_n        = '0;
         fill_n        = '0;
         state_n       = FILLING;
      end else if (in_valid) begin
         hist_n = hist_shift;
         match  = (fill_inc == FILL_FULL) && pattern_match(hist_shift, cfg_q);
         if (match && !cfg_q.overlap) begin
            fill_n = '0;
         end else begin
            fill_n = fill_inc;
         end
         state_n = (fill_n == FILL_FULL) ? ARMED : FILLING;
      end
   end

`ifdef HIT_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q;

   // Saturating hit counter. It advances on the same edge that raises hit,
   // and a clear in that cycle wins so the result is 0. Config writes leave
   // it alone.
   always_ff @(posedge clk) begin
      if (reset || cnt_clr) begin
         cnt_q <= '0;
      end else if (match && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign hit_cnt = cnt_q;
`else
   logic cnt_clr_unused;

   assign cnt_clr_unused = cnt_clr;
   assign hit_cnt        = '0;
`endif

endmodule

// File: rtl/multi_pattern_detector.sv
// multi_pattern_detector
// Serial bit-stream detector with NUM_PAT run-time programmable patterns of
// PAT_LEN bits (PAT_LEN comes from mpd_pkg). Each pattern has a care-mask,
// so don't-care positions are supported. Reports a per-channel hit vector
// and a combined any_hit, both one cycle after the accepting in_valid.
// Build option: define HIT_COUNT_EN for per-channel saturating hit counters;
// without it hit_cnt reads 0 and cnt_clr is ignored (ports are identical).
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   in_valid      in_bit is consumed this cycle
//   in_bit        serial data bit
//   cfg_we        write config for channel cfg_idx (ignored if out of range)
//   cfg_idx       target channel
//   cfg_pat       pattern, MSB = oldest bit
//   cfg_mask      1 = compare bit, 0 = don't care
//   cfg_overlap   per-channel mode bit, taken by the written channel
//   hit           registered one-cycle hit pulse per channel
//   any_hit       registered OR of the hits
//   cnt_clr       clear all hit counters
//   hit_cnt       saturating hit counts, ch0 in the LSBs
module multi_pattern_detector
   import mpd_pkg::*;
#(
   parameter  int NUM_PAT = 3,
   parameter  int CNT_W   = 8,
   localparam int IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic                     in_bit,
   input  logic                     cfg_we,
   input  logic [IDX_W-1:0]         cfg_idx,
   input  logic [PAT_LEN-1:0]       cfg_pat,
   input  logic [PAT_LEN-1:0]       cfg_mask,
   input  logic [NUM_PAT-1:0]       cfg_overlap,
   output logic [NUM_PAT-1:0]       hit,
   output logic                     any_hit,
   input  logic                     cnt_clr,
   output logic [NUM_PAT*CNT_W-1:0] hit_cnt
);

   logic [NUM_PAT-1:0] ch_we;
   logic [NUM_PAT-1:0] ch_match;

   // One channel per pattern. An out-of-range cfg_idx matches no channel,
   // so such a write simply has no effect.
   for (genvar i = 0; i < NUM_PAT; i++) begin : g_ch
      assign ch_we[i] = cfg_we && (cfg_idx == IDX_W'(i));

      mpd_channel #(
         .CNT_W (CNT_W)
      ) u_channel (
         .clk         (clk),
         .reset       (reset),
         .in_valid    (in_valid),
         .in_bit      (in_bit),
         .cfg_we      (ch_we[i]),
         .cfg_pat     (cfg_pat),
         .cfg_mask    (cfg_mask),
         .cfg_overlap (cfg_overlap[i]),
         .cnt_clr     (cnt_clr),
         .hit         (hit[i]),
         .match       (ch_match[i]),
         .hit_cnt     (hit_cnt[i*CNT_W +: CNT_W])
      );
   end

   // any_hit is registered from the channels' next-state hits so it lines up
   // with the hit vector instead of trailing it by a cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         any_hit <= 1'b0;
      end else begin
         any_hit <= |ch_match;
      end
   end

endmodule

// File: tb/tb_multi_pattern_detector.sv
// tb_multi_pattern_detector
// Directed self-checking bench for multi_pattern_detector with PAT_LEN=3,
// NUM_PAT=3 and CNT_W=2. Inputs change on the falling edge; outputs are read
// on the following falling edge, after the DUT's rising edge has sampled them.
// The counter scenario is selected by HIT_COUNT_EN, matching the RTL build.
module tb_multi_pattern_detector;

   localparam int NUM_PAT = 3;
   localparam int CNT_W   = 2;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     in_valid;
   logic                     in_bit;
   logic                     cfg_we;
   logic [1:0]               cfg_idx;
   logic [2:0]               cfg_pat;
   logic [2:0]               cfg_mask;
   logic [NUM_PAT-1:0]       cfg_overlap;
   logic [NUM_PAT-1:0]       hit;
   logic                     any_hit;
   logic                     cnt_clr;
   logic [NUM_PAT*CNT_W-1:0] hit_cnt;

   int vectors     = 0;
   int miscompares = 0;

   multi_pattern_detector #(
      .NUM_PAT (NUM_PAT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_pat     (cfg_pat),
      .cfg_mask    (cfg_mask),
      .cfg_overlap (cfg_overlap),
      .hit         (hit),
      .any_hit     (any_hit),
      .cnt_clr     (cnt_clr),
      .hit_cnt     (hit_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's worth of inputs, then wait for the next falling edge
   // so the result of that cycle is visible on the outputs.
   task automatic applyStimulus(input logic v, input logic b, input logic we,
                                input logic [1:0] idx, input logic [2:0] pat,
                                input logic [2:0] mask, input logic [2:0] ovl,
                                input logic clr);
      in_valid    = v;
      in_bit      = b;
      cfg_we      = we;
      cfg_idx     = idx;
      cfg_pat     = pat;
      cfg_mask    = mask;
      cfg_overlap = ovl;
      cnt_clr     = clr;
      @(negedge clk);
   endtask

   task automatic writeCfg(input logic [1:0] idx, input logic [2:0] pat,
                           input logic [2:0] mask, input logic [2:0] ovl);
      applyStimulus(1'b0, 1'b0, 1'b1, idx, pat, mask, ovl, 1'b0);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0);
   endtask

   task automatic checkHits(input string tag, input logic [2:0] exp_hit);
      checkOutput({tag, ".hit"}, 32'(hit), 32'(exp_hit));
      checkOutput({tag, ".any"}, 32'(any_hit), 32'(|exp_hit));
   endtask

   task automatic sendAndCheck(input string tag, input logic b, input logic [2:0] exp_hit);
      applyStimulus(1'b1, b, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0);
      checkHits(tag, exp_hit);
   endtask

   task automatic doReset();
      reset = 1'b1;
      idleCycle();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b0);
      idleCycle();
      checkHits("reset", 3'b000);
      checkOutput("reset.cnt", 32'(hit_cnt), 32'h0);
      reset = 1'b0;

      // Three channels, stream 0,1,1,0,1
      writeCfg(2'd0, 3'b011, 3'b111, 3'b111);
      writeCfg(2'd1, 3'b101, 3'b111, 3'b111);
      writeCfg(2'd2, 3'b110, 3'b110, 3'b111);
      sendAndCheck("t1.b1", 1'b0, 3'b000);
      sendAndCheck("t1.b2", 1'b1, 3'b000);
      sendAndCheck("t1.b3", 1'b1, 3'b001);
      sendAndCheck("t1.b4", 1'b0, 3'b100);
      sendAndCheck("t1.b5", 1'b1, 3'b010);
      idleCycle();
      checkHits("t1.idle", 3'b000);
`ifndef HIT_COUNT_EN
      checkOutput("t1.nocnt", 32'(hit_cnt), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b1);
      checkOutput("t1.nocnt_clr", 32'(hit_cnt), 32'h0);
`endif

      // Overlapping 101 on ch1
      doReset();
      writeCfg(2'd1, 3'b101, 3'b111, 3'b010);
      begin
         logic [6:0] bits;
         logic [6:0] exp_ov;
         logic [6:0] exp_no;
         bits   = 7'b1010101;
         exp_ov = 7'b0010101;
         exp_no = 7'b0010001;
         for (int i = 0; i < 7; i++)
            sendAndCheck($sformatf("t2.ov%0d", i + 1), bits[6-i], {1'b0, exp_ov[6-i], 1'b0});
         // Non-overlapping: the write also empties the channel
         writeCfg(2'd1, 3'b101, 3'b111, 3'b000);
         for (int i = 0; i < 7; i++)
            sendAndCheck($sformatf("t2.no%0d", i + 1), bits[6-i], {1'b0, exp_no[6-i], 1'b0});
      end

      // Unprogrammed channels never hit
      doReset();
      sendAndCheck("t3.b1", 1'b1, 3'b000);
      sendAndCheck("t3.b2", 1'b1, 3'b000);
      sendAndCheck("t3.b3", 1'b1, 3'b000);
      sendAndCheck("t3.b4", 1'b0, 3'b000);
      sendAndCheck("t3.b5", 1'b1, 3'b000);

      // Config write colliding with a bit: ch0 drops it, ch1 still hits
      doReset();
      writeCfg(2'd0, 3'b011, 3'b111, 3'b001);
      writeCfg(2'd1, 3'b011, 3'b111, 3'b010);
      sendAndCheck("t4.b1", 1'b0, 3'b000);
      sendAndCheck("t4.b2", 1'b1, 3'b000);
      applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 3'b011, 3'b111, 3'b001, 1'b0);
      checkHits("t4.collide", 3'b010);
      sendAndCheck("t4.n1", 1'b0, 3'b000);
      sendAndCheck("t4.n2", 1'b1, 3'b000);
      sendAndCheck("t4.n3", 1'b1, 3'b011);

      // Reset mid-stream, then an out-of-range write mid-stream
      doReset();
      writeCfg(2'd0, 3'b011, 3'b111, 3'b001);
      sendAndCheck("t5.b1", 1'b0, 3'b000);
      sendAndCheck("t5.b2", 1'b1, 3'b000);
      doReset();
      checkHits("t5.rst", 3'b000);
      sendAndCheck("t5.b3", 1'b1, 3'b000);
      writeCfg(2'd0, 3'b011, 3'b111, 3'b001);
      sendAndCheck("t5.c1", 1'b0, 3'b000);
      sendAndCheck("t5.c2", 1'b1, 3'b000);
      writeCfg(2'd3, 3'b101, 3'b111, 3'b000);
      checkHits("t5.bad_idx", 3'b000);
      idleCycle();
      sendAndCheck("t5.c3", 1'b1, 3'b001);

`ifdef HIT_COUNT_EN
      // Saturating counter on ch0 with pattern 111
      doReset();
      writeCfg(2'd0, 3'b111, 3'b111, 3'b001);
      sendAndCheck("t6.f1", 1'b1, 3'b000);
      sendAndCheck("t6.f2", 1'b1, 3'b000);
      begin
         logic [1:0] exp_cnt [5];
         exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
         for (int i = 0; i < 5; i++) begin
            sendAndCheck($sformatf("t6.h%0d", i + 1), 1'b1, 3'b001);
            checkOutput($sformatf("t6.cnt%0d", i + 1), 32'(hit_cnt), 32'(exp_cnt[i]));
         end
      end
      writeCfg(2'd0, 3'b111, 3'b111, 3'b001);
      checkOutput("t6.cfg_keep", 32'(hit_cnt), 32'h3);
      sendAndCheck("t6.r1", 1'b1, 3'b000);
      sendAndCheck("t6.r2", 1'b1, 3'b000);
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 1'b1);
      checkHits("t6.clr", 3'b001);
      checkOutput("t6.clr_cnt", 32'(hit_cnt), 32'h0);
`endif

      idleCycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
